vram_write_scheduler: RTL
=========================

// Module: vram_write_scheduler
// PURPOSE
//  Sequences all writes into the GPU VRAM port (data/address) so VRAM changes only while video timing reports `writable`.
//  Two requesters share the port: CPU byte writes (buffered in a FIFO) and a fill engine that block-sets a VRAM range.
//  Sits between the bus decode and gpu_m. Emits at most one registered VRAM write per clk.
// PARAMETERS
//  ADDR_W      13  VRAM address width (matches `VRAM_ADDR_WIDTH)
//  FIFO_DEPTH  16  CPU write FIFO entries (power of 2, >=2)
// PORTS
//  clk           in   1       pixel clock (12.5875 MHz)
//  rst           in   1       synchronous, active-high reset
//  writable      in   1       VRAM write window from video timing
//  cpu_wr_valid  in   1       CPU write request
//  cpu_wr_ready  out  1       FIFO can accept (push = valid & ready)
//  cpu_wr_addr   in   ADDR_W  CPU write address
//  cpu_wr_data   in   8       CPU write data
//  fill_start    in   1       1-cycle pulse: start fill
//  fill_base     in   ADDR_W  fill first address
//  fill_len      in   ADDR_W+1  fill byte count (0..2^ADDR_W)
//  fill_value    in   8       fill byte
//  fill_busy     out  1       fill engine active
//  fill_done     out  1       1-cycle pulse at fill completion
//  vram_we       out  1       registered write strobe to VRAM
//  vram_address  out  ADDR_W  registered write address
//  vram_data     out  8       registered write data
//  fifo_count    out  $clog2(FIFO_DEPTH)+1  CPU FIFO occupancy
// BEHAVIOUR
//  Reset: FIFO empty, fifo_count=0, cpu_wr_ready=1, fill FSM IDLE, fill_busy=0, fill_done=0, vram_we=0, vram_address=0, vram_data=0, rr_last=FILL (CPU wins first tie).
//  FIFO:
//   - cpu_wr_ready = !full. It is registered-state based and does not look at a same-cycle pop.
//   - Push and pop in the same cycle leave the count unchanged.
//   - When full, ready=0; a pop that cycle frees the slot for the next cycle.
//   - Pop only when not empty. Write order is preserved.
//  Fill FSM:
//   - IDLE: fill_start with fill_len!=0 latches base/len/value and moves to FILL (fill_busy=1 next cycle).
//   - IDLE: fill_start with fill_len==0 pulses fill_done next cycle and stays in IDLE.
//   - FILL: each grant issues the current address, then addr+1 mod 2^ADDR_W (wraps) and remaining-1.
//   - FILL: the grant that consumes the last byte moves to IDLE; fill_done pulses and fill_busy=0 in the cycle that byte appears on vram_*.
//   - fill_start while busy is ignored (no restart, no re-latch).
//  Arbitration (cycle N):
//   - No grant when writable=0.
//   - Otherwise candidates are: FIFO non-empty, FILL pending.
//   - One candidate: it wins. Both: round-robin against rr_last, and the winner updates rr_last.
//  Output timing:
//   - A grant in cycle N drives vram_we=1 with its addr/data in cycle N+1 (latency 1).
//   - Otherwise vram_we=0 and vram_address/vram_data hold their last values.
//   - writable is sampled only at grant. A write granted in the last writable cycle still appears one cycle after writable falls; the VRAM side accepts this.
//  Throughput: 1 write/cycle while writable. CPU and fill alternate when both are pending, so neither starves.
//  Widths: fill remaining counter is ADDR_W+1 bits; fill_len=2^ADDR_W writes every location exactly once.
//  Reset mid-operation: synchronous rst discards FIFO contents, aborts the fill without a fill_done pulse, and forces vram_we=0 next cycle.
// TESTING
//  1. writable=0, push 3 CPU writes (0x010<-AA, 0x011<-BB, 0x012<-CC) -> no vram_we, fifo_count=3; raise writable -> vram_we on 3 consecutive cycles in order, 1 cycle after each grant.
//  2. writable=0, push FIFO_DEPTH writes -> cpu_wr_ready=0 at count 16 and the 17th write is held. Raise writable with valid held -> one pop; the held write is accepted the next cycle and count stays 16.
//  3. Fill base=0x1FFE, len=4, value=0x55, writable=1 -> writes 1FFE,1FFF,0000,0001; fill_done pulses with the 0001 write.
//  4. FIFO holds 2 writes and fill len=3 starts; writable=1 -> grant order CPU,FILL,CPU,FILL,FILL.
//  5. fill_len=0 start -> fill_done pulse next cycle, fill_busy stays 0, no vram_we. fill_start while busy -> no effect on address sequence.
//  6. Assert rst mid-fill with FIFO=5 entries -> next cycle vram_we=0, fifo_count=0, fill_busy=0, no fill_done.

Source files
------------

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: serialises CPU byte writes (via a FIFO) and fill-engine
// block writes onto the single VRAM write port, only while video timing allows.
module vram_write_scheduler #(
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          writable,
  input  logic                          cpu_wr_valid,
  output logic                          cpu_wr_ready,
  input  logic [ADDR_W-1:0]             cpu_wr_addr,
  input  logic [7:0]                    cpu_wr_data,
  input  logic                          fill_start,
  input  logic [ADDR_W-1:0]             fill_base,
  input  logic [ADDR_W:0]               fill_len,
  input  logic [7:0]                    fill_value,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic                          vram_we,
  output logic [ADDR_W-1:0]             vram_address,
  output logic [7:0]                    vram_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REM_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic RR_CPU  = 1'b0;
  localparam logic RR_FILL = 1'b1;

  typedef enum logic {S_IDLE, S_FILL} fill_state_t;

  // FIFO storage (data only, never reset) and control state
  logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [7:0]        fifo_data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Fill engine state
  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [REM_W-1:0]  fill_rem_q, fill_rem_d;
  logic [7:0]        fill_val_q, fill_val_d;
  logic              fill_done_q, fill_done_d;

  // Arbitration and output registers
  logic              rr_last_q, rr_last_d;
  logic              vram_we_q, vram_we_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [7:0]        vram_data_q, vram_data_d;

  logic fifo_empty, fifo_full, fill_pend, contend;
  logic grant_cpu, grant_fill, push, pop;

  // Grant selection: one winner per writable cycle, round-robin only on contention
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    fill_pend  = (state_q == S_FILL);
    contend    = writable && !fifo_empty && fill_pend;
    grant_cpu  = 1'b0;
    grant_fill = 1'b0;
    rr_last_d  = rr_last_q;
    if (writable) begin
      if (contend) begin
        if (rr_last_q == RR_FILL) grant_cpu = 1'b1;
        else                      grant_fill = 1'b1;
        rr_last_d = grant_cpu ? RR_CPU : RR_FILL;
      end else if (!fifo_empty) begin
        grant_cpu = 1'b1;
      end else if (fill_pend) begin
        grant_fill = 1'b1;
      end
    end
  end

  // FIFO pointer/occupancy update; ready depends only on registered fullness
  always_comb begin
    push     = cpu_wr_valid && !fifo_full;
    pop      = grant_cpu;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // Fill engine next state: latch on start, step address/remaining per grant
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_rem_d  = fill_rem_q;
    fill_val_d  = fill_val_q;
    fill_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          if (fill_len == '0) begin
            fill_done_d = 1'b1;
          end else begin
            state_d     = S_FILL;
            fill_addr_d = fill_base;
            fill_rem_d  = fill_len;
            fill_val_d  = fill_value;
          end
        end
      end
      S_FILL: begin
        if (grant_fill) begin
          fill_addr_d = fill_addr_q + ADDR_W'(1);
          fill_rem_d  = fill_rem_q - REM_W'(1);
          if (fill_rem_q == REM_W'(1)) begin
            state_d     = S_IDLE;
            fill_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register next values: hold address/data when nothing is granted
  always_comb begin
    vram_we_d   = grant_cpu || grant_fill;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    if (grant_cpu) begin
      vram_addr_d = fifo_addr_mem[rd_ptr_q];
      vram_data_d = fifo_data_mem[rd_ptr_q];
    end else if (grant_fill) begin
      vram_addr_d = fill_addr_q;
      vram_data_d = fill_val_q;
    end
  end

  // FIFO payload write
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_q] <= cpu_wr_addr;
      fifo_data_mem[wr_ptr_q] <= cpu_wr_data;
    end
  end

  // Fill payload registers (only meaningful while the FSM is in S_FILL)
  always_ff @(posedge clk) begin
    fill_addr_q <= fill_addr_d;
    fill_rem_q  <= fill_rem_d;
    fill_val_q  <= fill_val_d;
  end

  // Control state, fill FSM and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      fill_done_q <= 1'b0;
      rr_last_q   <= RR_FILL;
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      fill_done_q <= fill_done_d;
      rr_last_q   <= rr_last_d;
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
    end
  end

  assign cpu_wr_ready = !fifo_full;
  assign fifo_count   = count_q;
  assign fill_busy    = (state_q == S_FILL);
  assign fill_done    = fill_done_q;
  assign vram_we      = vram_we_q;
  assign vram_address = vram_addr_q;
  assign vram_data    = vram_data_q;

endmodule
